// File: rtl/alu_pkg.sv
// Shared ALU select codes and multiply sequencer state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [SEL_W-1:0] ALU_NOT  = 3'd1;
  localparam logic [SEL_W-1:0] ALU_AND  = 3'd2;
  localparam logic [SEL_W-1:0] ALU_OR   = 3'd3;
  localparam logic [SEL_W-1:0] ALU_SRA  = 3'd4;
  localparam logic [SEL_W-1:0] ALU_SLL  = 3'd5;
  localparam logic [SEL_W-1:0] ALU_BEQ  = 3'd6;
  localparam logic [SEL_W-1:0] ALU_BNEQ = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_sched.sv
// Shift-and-add 8x8 multiply sequencer that borrows the shared datapath ALU,
// stalling the core while it owns it.
module alu_mul_sched
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  input  logic [DATA_W-1:0] core_a,
  input  logic [DATA_W-1:0] core_b,
  input  logic [SEL_W-1:0]  core_sel,
  output logic [DATA_W-1:0] core_f,
  output logic              core_take_branch,
  output logic              core_stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_take_branch
);

  state_t            state_q, state_n;
  logic [DATA_W-1:0] acc_q, acc_n;
  logic [DATA_W-1:0] m_q, m_n;
  logic [DATA_W-1:0] q_q, q_n;
  logic [DATA_W-1:0] product_q, product_n;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] mul_a, mul_b;
  logic [SEL_W-1:0]  mul_sel;
  logic              core_owns;

  // State and datapath registers; busy/done are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      m_q       <= m_n;
      q_q       <= q_n;
      product_q <= product_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == DONE);
    end
  end

  // Next-state and ALU request for the multiply sequence.
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    m_n       = m_q;
    q_n       = q_q;
    product_n = product_q;
    mul_a     = '0;
    mul_b     = '0;
    mul_sel   = ALU_ADD;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_n     = op_a;
          q_n     = op_b;
          acc_n   = '0;
          state_n = TEST;
        end
      end
      TEST: begin
        mul_sel = ALU_BEQ;
        mul_a   = q_q;
        if (alu_take_branch) state_n = DONE;
        else if (q_q[0])     state_n = ADD;
        else                 state_n = SHIFT;
      end
      ADD: begin
        mul_sel = ALU_ADD;
        mul_a   = acc_q;
        mul_b   = m_q;
        acc_n   = alu_f;
        state_n = SHIFT;
      end
      SHIFT: begin
        mul_sel = ALU_SLL;
        mul_a   = m_q;
        m_n     = alu_f;
        q_n     = {1'b0, q_q[DATA_W-1:1]};
        state_n = TEST;
      end
      DONE: begin
        product_n = acc_q;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ALU ownership follows the state register, so reset hands it back at once.
  assign core_owns        = (state_q == IDLE);
  assign alu_a            = core_owns ? core_a   : mul_a;
  assign alu_b            = core_owns ? core_b   : mul_b;
  assign alu_sel          = core_owns ? core_sel : mul_sel;
  assign core_f           = core_owns ? alu_f    : '0;
  assign core_take_branch = core_owns ? alu_take_branch : 1'b0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign core_stall = busy_q;
  assign product    = product_q;

endmodule
